// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Registered valid/ready stream demultiplexer. Each input word carries a
//   destination index (in_sel). The word is steered to one of NUM_OUT output
//   streams through a single-entry output register. Latency is 1 cycle and
//   throughput is 1 word/cycle. Words whose select is out of range are dropped:
//   each drop raises err_drop for one cycle and increments a saturating
//   8-bit counter.
//
// Ports
//   clk         in   1        clock, all logic on posedge
//   rst         in   1        synchronous active-high reset
//   in_valid    in   1        input word valid
//   in_ready    out  1        block can accept the input word (combinational)
//   in_data     in   WIDTH    input word
//   in_sel      in   SEL_W    destination index, sampled with in_data
//   out_valid   out  NUM_OUT  per-output valid, one-hot or zero
//   out_ready   in   NUM_OUT  per-output ready
//   out_data    out  WIDTH    shared output data bus, qualified by out_valid
//   err_drop    out  1        1-cycle pulse after an out-of-range word is dropped
//   drop_count  out  8        saturating count of dropped words
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 2,
  localparam int SEL_W  = $clog2(NUM_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               err_drop,
  output logic [7:0]         drop_count
);

  // Slot state
  logic               slot_full_q, slot_full_d;
  logic [SEL_W-1:0]   slot_dest_q, slot_dest_d;
  logic [WIDTH-1:0]   slot_data_q, slot_data_d;
  logic               err_drop_q, err_drop_d;
  logic [7:0]         drop_count_q, drop_count_d;

  logic [NUM_OUT-1:0] out_valid_s;
  logic               fire_s;
  logic               accept_s;
  logic               sel_ok_s;
  logic               in_ready_s;

  // Decode the slot destination into per-output valids; fire when the
  // targeted output is ready (readies of other outputs are masked off).
  always_comb begin
    out_valid_s = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_valid_s[i] = slot_full_q && (slot_dest_q == SEL_W'(i));
    end
    fire_s = |(out_valid_s & out_ready);
  end

  // The extra top bit keeps the compare exact when NUM_OUT is a power of
  // two: then every select is in range and the compare folds to constant 1.
  assign sel_ok_s   = ({1'b0, in_sel} < (SEL_W + 1)'(NUM_OUT));
  assign in_ready_s = !rst && (!slot_full_q || fire_s);
  assign accept_s   = in_valid && in_ready_s;

  // Next-state logic for the slot and the drop bookkeeping.
  always_comb begin
    slot_full_d  = slot_full_q;
    slot_dest_d  = slot_dest_q;
    slot_data_d  = slot_data_q;
    err_drop_d   = 1'b0;
    drop_count_d = drop_count_q;

    if (fire_s) begin
      slot_full_d = 1'b0;
    end else begin
      slot_full_d = slot_full_q;
    end

    if (accept_s && sel_ok_s) begin
      // A same-cycle fire and accept simply reloads the slot.
      slot_full_d = 1'b1;
      slot_dest_d = in_sel;
      slot_data_d = in_data;
    end else if (accept_s) begin
      err_drop_d = 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end else begin
        drop_count_d = drop_count_q;
      end
    end else begin
      err_drop_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full_q  <= 1'b0;
      slot_dest_q  <= '0;
      slot_data_q  <= '0;
      err_drop_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      slot_full_q  <= slot_full_d;
      slot_dest_q  <= slot_dest_d;
      slot_data_q  <= slot_data_d;
      err_drop_q   <= err_drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign out_data   = slot_data_q;
  assign err_drop   = err_drop_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

  localparam int WIDTH   = 8;
  localparam int NUM_OUT = 3;
  localparam int SEL_W   = 2;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               err_drop;
  logic [7:0]         drop_count;

  int vectors;
  int miscompares;

  stream_demux #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err_drop   (err_drop),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [1:0] sel;
    logic [7:0] data;
    logic [2:0] ordy;
    logic       e_rdy;   // in_ready before the edge
    logic [2:0] e_ov;    // out_valid after the edge
    logic       chk_d;   // compare out_data after the edge
    logic [7:0] e_od;
    logic       e_err;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Upstream obligation: a stalled input word must not change.
  logic       prev_stall;
  logic [7:0] prev_data;
  logic [1:0] prev_sel;
  always @(posedge clk) begin
    if (prev_stall && !rst && in_valid && ((in_data !== prev_data) || (in_sel !== prev_sel))) begin
      miscompares++;
      $display("FAIL upstream_stable: data %0h sel %0h expected data %0h sel %0h",
               in_data, in_sel, prev_data, prev_sel);
    end
    prev_stall = in_valid && !in_ready && !rst;
    prev_data  = in_data;
    prev_sel   = in_sel;
  end

  // Random-phase scoreboard state
  logic [7:0] sbq [NUM_OUT][$];
  int         exp_drops;
  logic [2:0] p_ov;
  logic [7:0] p_od;
  logic       p_hold;

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_stall  = 1'b0;
    prev_data   = 8'h00;
    prev_sel    = 2'd0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    in_sel      = 2'd0;
    out_ready   = 3'b000;

    //          rst   iv    sel   data   ordy    rdy   ov      chk   od     err   cnt
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 3'b111, 1'b0, 3'b000, 1'b1, 8'h00, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 8'h77, 3'b111, 1'b0, 3'b000, 1'b1, 8'h00, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 8'hAA, 3'b111, 1'b1, 3'b001, 1'b1, 8'hAA, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 8'h55, 3'b111, 1'b1, 3'b010, 1'b1, 8'h55, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 2'd2, 8'h3C, 3'b011, 1'b1, 3'b100, 1'b1, 8'h3C, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b011, 1'b0, 3'b100, 1'b1, 8'h3C, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b011, 1'b0, 3'b100, 1'b1, 8'h3C, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b011, 1'b0, 3'b100, 1'b1, 8'h3C, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 2'd3, 8'hFF, 3'b111, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 8'h12, 3'b000, 1'b1, 3'b010, 1'b1, 8'h12, 1'b0, 8'd1};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b000, 1'b0, 3'b010, 1'b1, 8'h12, 1'b0, 8'd1};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b101, 1'b0, 3'b010, 1'b1, 8'h12, 1'b0, 8'd1};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b1, 8'h00, 1'b0, 8'd0};
    vecs[15] = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 8'd0};

    // Directed table
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      rst       = vecs[v].rst;
      in_valid  = vecs[v].iv;
      in_sel    = vecs[v].sel;
      in_data   = vecs[v].data;
      out_ready = vecs[v].ordy;
      #1;
      vectors++;
      chk($sformatf("v%0d in_ready", v), 32'(in_ready), 32'(vecs[v].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", v), 32'(out_valid), 32'(vecs[v].e_ov));
      if (vecs[v].chk_d) chk($sformatf("v%0d out_data", v), 32'(out_data), 32'(vecs[v].e_od));
      chk($sformatf("v%0d err_drop", v), 32'(err_drop), 32'(vecs[v].e_err));
      chk($sformatf("v%0d drop_count", v), 32'(drop_count), 32'(vecs[v].e_cnt));
    end

    // 300 back-to-back invalid words: counter saturates at 255
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sel    = 2'd3;
      in_data   = 8'(k);
      out_ready = 3'b111;
      #1;
      vectors++;
      chk($sformatf("drop%0d in_ready", k), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("drop%0d out_valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("drop%0d err_drop", k), 32'(err_drop), 32'd1);
      chk($sformatf("drop%0d drop_count", k), 32'(drop_count), (k > 255) ? 32'd255 : 32'(k));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    chk("drop_end err_drop", 32'(err_drop), 32'd0);
    chk("drop_end drop_count", 32'(drop_count), 32'd255);

    // Reset before random traffic
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    chk("rand_start drop_count", 32'(drop_count), 32'd0);

    // Random traffic with per-output scoreboard
    exp_drops = 0;
    p_hold    = 1'b0;
    p_ov      = 3'b000;
    p_od      = 8'h00;
    for (int c = 0; c < 10010; c++) begin
      @(negedge clk);
      if (c >= 10000) begin
        in_valid  = 1'b0;
        out_ready = 3'b111;
      end else begin
        if (!(in_valid && !in_ready)) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_sel   = 2'($urandom_range(0, 3));
          in_data  = 8'($urandom_range(0, 255));
        end
        out_ready = 3'($urandom_range(0, 7));
      end
      #1;
      vectors++;
      if ($countones(out_valid) > 1) chk("rand onehot", 32'(out_valid), 32'd0);
      if (p_hold) begin
        chk("rand hold out_valid", 32'(out_valid), 32'(p_ov));
        chk("rand hold out_data", 32'(out_data), 32'(p_od));
      end
      for (int i = 0; i < NUM_OUT; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (sbq[i].size() == 0) begin
            chk($sformatf("rand out%0d unexpected word", i), 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("rand out%0d data", i), 32'(out_data), 32'(sbq[i].pop_front()));
          end
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel < 2'd3) sbq[in_sel].push_back(in_data);
        else exp_drops++;
      end
      p_hold = |(out_valid & ~out_ready);
      p_ov   = out_valid;
      p_od   = out_data;
    end
    #1;
    vectors++;
    for (int i = 0; i < NUM_OUT; i++) chk($sformatf("rand out%0d leftover", i), 32'(sbq[i].size()), 32'd0);
    chk("rand drop_count", 32'(drop_count), (exp_drops > 255) ? 32'd255 : 32'(exp_drops));
    if (exp_drops < 255) chk("rand drops min", 32'(exp_drops), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
